// File: rtl/pcd8544_pkg.sv
// Shared types, opcode masks and defaults for the PCD8544 SPI receiver.
package pcd8544_pkg;

    localparam int unsigned NB_COLUMNS_DEF  = 84;
    localparam int unsigned NB_BANKS_DEF    = 6;
    localparam int unsigned SYNC_STAGES_DEF = 2;

    localparam int unsigned X_W       = 7;
    localparam int unsigned Y_W       = 3;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned BIT_CNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SHIFT    = 2'd1,
        ST_DISPATCH = 2'd2
    } state_e;

    // {D,E} display control encodings
    typedef enum logic [1:0] {
        DM_BLANK   = 2'b00,
        DM_ALL_ON  = 2'b01,
        DM_NORMAL  = 2'b10,
        DM_INVERSE = 2'b11
    } disp_mode_e;

    // Command opcode masks/values (match when (byte & MASK) == VAL)
    localparam logic [7:0] CMD_NOP        = 8'h00;
    localparam logic [7:0] CMD_FSET_MASK  = 8'hF8;
    localparam logic [7:0] CMD_FSET_VAL   = 8'h20;
    localparam logic [7:0] CMD_DCTL_MASK  = 8'hFA;
    localparam logic [7:0] CMD_DCTL_VAL   = 8'h08;
    localparam logic [7:0] CMD_SETY_MASK  = 8'hF8;
    localparam logic [7:0] CMD_SETY_VAL   = 8'h40;
    localparam logic [7:0] CMD_SETX_MASK  = 8'h80;
    localparam logic [7:0] CMD_SETX_VAL   = 8'h80;
    localparam logic [7:0] CMD_TC_MASK    = 8'hFC;
    localparam logic [7:0] CMD_TC_VAL     = 8'h04;
    localparam logic [7:0] CMD_BIAS_MASK  = 8'hF8;
    localparam logic [7:0] CMD_BIAS_VAL   = 8'h10;
    localparam logic [7:0] CMD_VOP_MASK   = 8'h80;
    localparam logic [7:0] CMD_VOP_VAL    = 8'h80;

    function automatic logic cmd_match(input logic [7:0] b,
                                       input logic [7:0] mask,
                                       input logic [7:0] val);
        return (b & mask) == val;
    endfunction

endpackage

// File: rtl/pcd8544_spi_receiver_spi_input_sync.sv
// Synchronises the SPI pins into clk_main and detects SCLK rise / SCE fall.
module spi_input_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_main,
    input  logic rst_n,
    input  logic i_sce,
    input  logic i_sclk,
    input  logic i_mosi,
    input  logic i_d_c,
    output logic o_sce,
    output logic o_mosi,
    output logic o_d_c,
    output logic o_sclk_rise_c,
    output logic o_sce_fall_c
);

    logic [SYNC_STAGES-1:0] r_sce_sync;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_d_c_sync;
    logic                   r_sclk_prev;
    logic                   r_sce_prev;

    // Synchroniser chains; SCE idles high so its chain resets to 1
    always_ff @(posedge clk_main or negedge rst_n) begin
        if (!rst_n) begin
            r_sce_sync  <= '1;
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_d_c_sync  <= '0;
            r_sclk_prev <= 1'b0;
            r_sce_prev  <= 1'b1;
        end else begin
            r_sce_sync  <= {r_sce_sync[SYNC_STAGES-2:0],  i_sce};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
            r_d_c_sync  <= {r_d_c_sync[SYNC_STAGES-2:0],  i_d_c};
            r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
            r_sce_prev  <= r_sce_sync[SYNC_STAGES-1];
        end
    end

    assign o_sce  = r_sce_sync[SYNC_STAGES-1];
    assign o_mosi = r_mosi_sync[SYNC_STAGES-1];
    assign o_d_c  = r_d_c_sync[SYNC_STAGES-1];

    // SCLK edges only count while the chip is selected
    assign o_sclk_rise_c = r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_prev & ~o_sce;
    assign o_sce_fall_c  = ~o_sce & r_sce_prev;

endmodule

// File: rtl/pcd8544_spi_receiver.sv
// PCD8544-compatible SPI decoder: byte assembly, command decode, frame-buffer writes.
module pcd8544_spi_receiver
    import pcd8544_pkg::*;
#(
    parameter int unsigned NB_COLUMNS  = NB_COLUMNS_DEF,
    parameter int unsigned NB_BANKS    = NB_BANKS_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic           clk_main,
    input  logic           rst_n,
    input  logic           spi_sce,
    input  logic           spi_clk,
    input  logic           spi_mosi,
    input  logic           spi_d_c,
    output logic           fb_wr_en,
    output logic [X_W-1:0] fb_x,
    output logic [Y_W-1:0] fb_y,
    output logic [7:0]     fb_data,
    output logic           frame_done,
    output logic [1:0]     disp_mode,
    output logic           power_down,
    output logic [6:0]     vop,
    output logic [2:0]     bias,
    output logic [1:0]     temp_coef,
    output logic           byte_err
);

    logic w_sce, w_mosi, w_d_c, w_sclk_rise, w_sce_fall;

    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_main      (clk_main),
        .rst_n         (rst_n),
        .i_sce         (spi_sce),
        .i_sclk        (spi_clk),
        .i_mosi        (spi_mosi),
        .i_d_c         (spi_d_c),
        .o_sce         (w_sce),
        .o_mosi        (w_mosi),
        .o_d_c         (w_d_c),
        .o_sclk_rise_c (w_sclk_rise),
        .o_sce_fall_c  (w_sce_fall)
    );

    state_e               r_state,   r_state_nxt;
    logic [BIT_CNT_W-1:0] r_bit_cnt, r_bit_cnt_nxt;
    logic [BYTE_W-1:0]    r_shift,   r_shift_nxt;
    logic                 r_dc,      r_dc_nxt;
    logic [X_W-1:0]       r_x,       r_x_nxt;
    logic [Y_W-1:0]       r_y,       r_y_nxt;
    logic                 r_h,       r_h_nxt;
    logic                 r_v,       r_v_nxt;
    logic                 r_fb_wr_en, r_fb_wr_en_nxt;
    logic [X_W-1:0]       r_fb_x,    r_fb_x_nxt;
    logic [Y_W-1:0]       r_fb_y,    r_fb_y_nxt;
    logic [7:0]           r_fb_data, r_fb_data_nxt;
    logic                 r_frame_done, r_frame_done_nxt;
    logic [1:0]           r_disp_mode, r_disp_mode_nxt;
    logic                 r_pd,      r_pd_nxt;
    logic [6:0]           r_vop,     r_vop_nxt;
    logic [2:0]           r_bias,    r_bias_nxt;
    logic [1:0]           r_tc,      r_tc_nxt;
    logic                 r_byte_err, r_byte_err_nxt;

    logic w_x_last, w_y_last;
    assign w_x_last = (r_x == X_W'(NB_COLUMNS - 1));
    assign w_y_last = (r_y == Y_W'(NB_BANKS - 1));

    // State and datapath registers
    always_ff @(posedge clk_main or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_dc         <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
            r_h          <= 1'b0;
            r_v          <= 1'b0;
            r_fb_wr_en   <= 1'b0;
            r_fb_x       <= '0;
            r_fb_y       <= '0;
            r_fb_data    <= '0;
            r_frame_done <= 1'b0;
            r_disp_mode  <= DM_BLANK;
            r_pd         <= 1'b1;
            r_vop        <= '0;
            r_bias       <= '0;
            r_tc         <= '0;
            r_byte_err   <= 1'b0;
        end else begin
            r_state      <= r_state_nxt;
            r_bit_cnt    <= r_bit_cnt_nxt;
            r_shift      <= r_shift_nxt;
            r_dc         <= r_dc_nxt;
            r_x          <= r_x_nxt;
            r_y          <= r_y_nxt;
            r_h          <= r_h_nxt;
            r_v          <= r_v_nxt;
            r_fb_wr_en   <= r_fb_wr_en_nxt;
            r_fb_x       <= r_fb_x_nxt;
            r_fb_y       <= r_fb_y_nxt;
            r_fb_data    <= r_fb_data_nxt;
            r_frame_done <= r_frame_done_nxt;
            r_disp_mode  <= r_disp_mode_nxt;
            r_pd         <= r_pd_nxt;
            r_vop        <= r_vop_nxt;
            r_bias       <= r_bias_nxt;
            r_tc         <= r_tc_nxt;
            r_byte_err   <= r_byte_err_nxt;
        end
    end

    // Next-state: byte assembly, then one dispatch cycle per complete byte
    always_comb begin
        r_state_nxt      = r_state;
        r_bit_cnt_nxt    = r_bit_cnt;
        r_shift_nxt      = r_shift;
        r_dc_nxt         = r_dc;
        r_x_nxt          = r_x;
        r_y_nxt          = r_y;
        r_h_nxt          = r_h;
        r_v_nxt          = r_v;
        r_fb_wr_en_nxt   = 1'b0;
        r_fb_x_nxt       = r_fb_x;
        r_fb_y_nxt       = r_fb_y;
        r_fb_data_nxt    = r_fb_data;
        r_frame_done_nxt = 1'b0;
        r_disp_mode_nxt  = r_disp_mode;
        r_pd_nxt         = r_pd;
        r_vop_nxt        = r_vop;
        r_bias_nxt       = r_bias;
        r_tc_nxt         = r_tc;
        r_byte_err_nxt   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                r_bit_cnt_nxt = '0;
                if (w_sce_fall) r_state_nxt = ST_SHIFT;
            end

            ST_SHIFT: begin
                if (w_sce) begin
                    // deselect mid-byte drops the partial byte
                    if (r_bit_cnt != '0) r_byte_err_nxt = 1'b1;
                    r_bit_cnt_nxt = '0;
                    r_state_nxt   = ST_IDLE;
                end else if (w_sclk_rise) begin
                    r_shift_nxt   = {r_shift[BYTE_W-2:0], w_mosi};
                    r_bit_cnt_nxt = BIT_CNT_W'(r_bit_cnt + 1'b1);
                    if (r_bit_cnt == BIT_CNT_W'(BYTE_W - 1)) begin
                        r_dc_nxt    = w_d_c;
                        r_state_nxt = ST_DISPATCH;
                    end
                end
            end

            ST_DISPATCH: begin
                r_bit_cnt_nxt = '0;
                r_state_nxt   = w_sce ? ST_IDLE : ST_SHIFT;
                if (r_dc) begin
                    r_fb_wr_en_nxt   = 1'b1;
                    r_fb_x_nxt       = r_x;
                    r_fb_y_nxt       = r_y;
                    r_fb_data_nxt    = r_shift;
                    r_frame_done_nxt = w_x_last && w_y_last;
                    if (!r_v) begin
                        if (w_x_last) begin
                            r_x_nxt = '0;
                            r_y_nxt = w_y_last ? '0 : Y_W'(r_y + 1'b1);
                        end else begin
                            r_x_nxt = X_W'(r_x + 1'b1);
                        end
                    end else begin
                        if (w_y_last) begin
                            r_y_nxt = '0;
                            r_x_nxt = w_x_last ? '0 : X_W'(r_x + 1'b1);
                        end else begin
                            r_y_nxt = Y_W'(r_y + 1'b1);
                        end
                    end
                end else if (r_shift == CMD_NOP) begin
                    r_pd_nxt = r_pd;
                end else if (cmd_match(r_shift, CMD_FSET_MASK, CMD_FSET_VAL)) begin
                    r_pd_nxt = r_shift[2];
                    r_v_nxt  = r_shift[1];
                    r_h_nxt  = r_shift[0];
                end else if (!r_h) begin
                    if (cmd_match(r_shift, CMD_DCTL_MASK, CMD_DCTL_VAL)) begin
                        r_disp_mode_nxt = {r_shift[2], r_shift[0]};
                    end else if (cmd_match(r_shift, CMD_SETY_MASK, CMD_SETY_VAL)) begin
                        if (r_shift[2:0] < Y_W'(NB_BANKS)) r_y_nxt = r_shift[2:0];
                    end else if (cmd_match(r_shift, CMD_SETX_MASK, CMD_SETX_VAL)) begin
                        if (r_shift[6:0] < X_W'(NB_COLUMNS)) r_x_nxt = r_shift[6:0];
                    end
                end else begin
                    if (cmd_match(r_shift, CMD_TC_MASK, CMD_TC_VAL)) begin
                        r_tc_nxt = r_shift[1:0];
                    end else if (cmd_match(r_shift, CMD_BIAS_MASK, CMD_BIAS_VAL)) begin
                        r_bias_nxt = r_shift[2:0];
                    end else if (cmd_match(r_shift, CMD_VOP_MASK, CMD_VOP_VAL)) begin
                        r_vop_nxt = r_shift[6:0];
                    end
                end
            end

            default: begin
                r_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign fb_wr_en   = r_fb_wr_en;
    assign fb_x       = r_fb_x;
    assign fb_y       = r_fb_y;
    assign fb_data    = r_fb_data;
    assign frame_done = r_frame_done;
    assign disp_mode  = r_disp_mode;
    assign power_down = r_pd;
    assign vop        = r_vop;
    assign bias       = r_bias;
    assign temp_coef  = r_tc;
    assign byte_err   = r_byte_err;

endmodule

// File: tb/tb_pcd8544_spi_receiver.sv
// Bench for pcd8544_spi_receiver: directed plan steps plus random bytes vs. a linear-address model.
module tb_pcd8544_spi_receiver;

    localparam int NBC = 84;
    localparam int NBB = 6;

    logic       clk_main = 1'b0;
    logic       rst_n    = 1'b0;
    logic       spi_sce  = 1'b1;
    logic       spi_clk  = 1'b0;
    logic       spi_mosi = 1'b0;
    logic       spi_d_c  = 1'b0;
    logic       fb_wr_en;
    logic [6:0] fb_x;
    logic [2:0] fb_y;
    logic [7:0] fb_data;
    logic       frame_done;
    logic [1:0] disp_mode;
    logic       power_down;
    logic [6:0] vop;
    logic [2:0] bias;
    logic [1:0] temp_coef;
    logic       byte_err;

    always #5 clk_main = ~clk_main;

    pcd8544_spi_receiver dut (
        .clk_main   (clk_main),
        .rst_n      (rst_n),
        .spi_sce    (spi_sce),
        .spi_clk    (spi_clk),
        .spi_mosi   (spi_mosi),
        .spi_d_c    (spi_d_c),
        .fb_wr_en   (fb_wr_en),
        .fb_x       (fb_x),
        .fb_y       (fb_y),
        .fb_data    (fb_data),
        .frame_done (frame_done),
        .disp_mode  (disp_mode),
        .power_down (power_down),
        .vop        (vop),
        .bias       (bias),
        .temp_coef  (temp_coef),
        .byte_err   (byte_err)
    );

    int total = 0;
    int bad   = 0;

    // observed / expected writes packed as {frame_done, x, y, data}
    logic [18:0] obs_q[$];
    logic [18:0] exp_q[$];
    int obs_err  = 0;
    int exp_err  = 0;
    int stray_fd = 0;

    // reference state
    int         mx, my;
    logic       mh, mv, mpd;
    logic [6:0] mvop;
    logic [2:0] mbias;
    logic [1:0] mtc, mmode;

    always @(negedge clk_main) begin
        if (fb_wr_en) obs_q.push_back({frame_done, fb_x, fb_y, fb_data});
        if (frame_done && !fb_wr_en) stray_fd++;
        if (byte_err) obs_err++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mx = 0; my = 0; mh = 1'b0; mv = 1'b0; mpd = 1'b1;
        mvop = '0; mbias = '0; mtc = '0; mmode = '0;
    endtask

    // Frame buffer modelled as linear address spaces: row-major or column-major
    task automatic model_byte(input logic [7:0] b, input logic dc);
        int a;
        if (dc) begin
            exp_q.push_back({(mx == NBC-1 && my == NBB-1), 7'(mx), 3'(my), b});
            if (!mv) begin
                a = (my * NBC + mx + 1) % (NBC * NBB);
                my = a / NBC; mx = a % NBC;
            end else begin
                a = (mx * NBB + my + 1) % (NBC * NBB);
                mx = a / NBB; my = a % NBB;
            end
        end else begin
            casez (b)
                8'b0000_0000: ;
                8'b0010_0???: begin mpd = b[2]; mv = b[1]; mh = b[0]; end
                default: begin
                    if (!mh) begin
                        casez (b)
                            8'b0000_1?0?: mmode = {b[2], b[0]};
                            8'b0100_0???: if (int'(b[2:0]) < NBB) my = int'(b[2:0]);
                            8'b1???_????: if (int'(b[6:0]) < NBC) mx = int'(b[6:0]);
                            default: ;
                        endcase
                    end else begin
                        casez (b)
                            8'b0000_01??: mtc = b[1:0];
                            8'b0001_0???: mbias = b[2:0];
                            8'b1???_????: mvop = b[6:0];
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    endtask

    // MSB-first bits; D/C is junk except on the final bit of a byte
    task automatic send_bits(input logic [7:0] b, input int n, input logic dc);
        for (int i = 7; i >= 8 - n; i--) begin
            @(negedge clk_main);
            spi_clk  = 1'b0;
            spi_mosi = b[i];
            spi_d_c  = (i == 0) ? dc : 1'($urandom);
            repeat (4) @(negedge clk_main);
            spi_clk = 1'b1;
            repeat (4) @(negedge clk_main);
        end
        spi_clk = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_nwr"}, 32'(obs_q.size()), 32'(exp_q.size()));
        while (obs_q.size() > 0 && exp_q.size() > 0)
            chk({tag, "_wr"}, 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
        obs_q.delete();
        exp_q.delete();
        chk({tag, "_err"}, 32'(obs_err), 32'(exp_err));
        chk({tag, "_regs"}, 32'({disp_mode, power_down, vop, bias, temp_coef}),
            32'({mmode, mpd, mvop, mbias, mtc}));
    endtask

    task automatic send_byte(input logic [7:0] b, input logic dc, input logic hold, input string tag);
        if (spi_sce) begin
            spi_sce = 1'b0;
            repeat (4) @(negedge clk_main);
        end
        send_bits(b, 8, dc);
        model_byte(b, dc);
        if (!hold) spi_sce = 1'b1;
        repeat (8) @(negedge clk_main);
        check_all(tag);
    endtask

    initial begin
        logic [7:0] b;
        logic       dc;
        model_reset();
        repeat (3) @(negedge clk_main);
        chk("rst_outs", 32'({fb_wr_en, fb_x, fb_y, fb_data, frame_done, disp_mode, vop, bias, temp_coef, byte_err}), 32'd0);
        chk("rst_pd", 32'(power_down), 32'd1);
        rst_n = 1'b1;
        repeat (4) @(negedge clk_main);

        // init sequence
        send_byte(8'h21, 1'b0, 1'b1, "init21");
        send_byte(8'hBF, 1'b0, 1'b1, "initBF");
        send_byte(8'h14, 1'b0, 1'b1, "init14");
        send_byte(8'h06, 1'b0, 1'b0, "init06");
        send_byte(8'h20, 1'b0, 1'b1, "init20");
        send_byte(8'h0C, 1'b0, 1'b0, "init0C");
        chk("init_vop",  32'(vop), 32'h3F);
        chk("init_bias", 32'(bias), 32'd4);
        chk("init_tc",   32'(temp_coef), 32'd2);
        chk("init_pd",   32'(power_down), 32'd0);
        chk("init_mode", 32'(disp_mode), 32'(2'b10));

        // horizontal addressing
        send_byte(8'h80, 1'b0, 1'b1, "h_x0");
        send_byte(8'h41, 1'b0, 1'b1, "h_y1");
        send_byte(8'hA5, 1'b1, 1'b1, "h_d0");
        send_byte(8'h5A, 1'b1, 1'b0, "h_d1");

        // last address -> frame_done and wrap
        send_byte(8'h80 | 8'd83, 1'b0, 1'b1, "last_x");
        send_byte(8'h45, 1'b0, 1'b1, "last_y");
        send_byte(8'hC3, 1'b1, 1'b1, "last_wr");
        send_byte(8'h3C, 1'b1, 1'b0, "wrap_wr");

        // vertical addressing
        send_byte(8'h22, 1'b0, 1'b1, "v_fset");
        send_byte(8'h80, 1'b0, 1'b1, "v_x0");
        send_byte(8'h45, 1'b0, 1'b1, "v_y5");
        send_byte(8'h11, 1'b1, 1'b1, "v_d0");
        send_byte(8'h22, 1'b1, 1'b1, "v_d1");
        send_byte(8'h33, 1'b1, 1'b0, "v_d2");

        // out-of-range X/Y ignored
        send_byte(8'h80 | 8'd90, 1'b0, 1'b1, "bad_x");
        send_byte(8'h47, 1'b0, 1'b1, "bad_y");
        send_byte(8'h33, 1'b1, 1'b0, "bad_wr");

        // truncated byte
        spi_sce = 1'b0;
        repeat (4) @(negedge clk_main);
        send_bits(8'hB7, 5, 1'b1);
        repeat (4) @(negedge clk_main);
        spi_sce = 1'b1;
        exp_err++;
        repeat (10) @(negedge clk_main);
        check_all("partial");
        send_byte(8'hFF, 1'b1, 1'b0, "after_partial");

        // random traffic
        for (int k = 0; k < 150; k++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: begin b = 8'($urandom); dc = 1'b1; end
                4: begin b = 8'h20 | 8'($urandom_range(0, 7)); dc = 1'b0; end
                5: begin b = 8'h80 | 8'($urandom); dc = 1'b0; end
                6: begin b = 8'h40 | 8'($urandom_range(0, 7)); dc = 1'b0; end
                7: begin b = 8'h08 | 8'($urandom_range(0, 7)); dc = 1'b0; end
                8: begin b = 8'h04 | 8'($urandom_range(0, 19)); dc = 1'b0; end
                default: begin b = 8'($urandom); dc = 1'b0; end
            endcase
            send_byte(b, dc, 1'($urandom), "rnd");
        end

        // reset mid-byte
        spi_sce = 1'b1;
        repeat (4) @(negedge clk_main);
        spi_sce = 1'b0;
        repeat (4) @(negedge clk_main);
        send_bits(8'h96, 4, 1'b1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk_main);
        chk("mid_rst_outs", 32'({fb_wr_en, fb_x, fb_y, fb_data, frame_done, disp_mode, vop, bias, temp_coef, byte_err}), 32'd0);
        chk("mid_rst_pd", 32'(power_down), 32'd1);
        spi_sce = 1'b1;
        repeat (4) @(negedge clk_main);
        rst_n = 1'b1;
        model_reset();
        obs_q.delete();
        exp_q.delete();
        obs_err = 0;
        exp_err = 0;
        repeat (4) @(negedge clk_main);
        send_byte(8'h5E, 1'b1, 1'b0, "post_rst");

        chk("stray_frame_done", 32'(stray_fd), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pcd8544_spi_receiver.md
Name: pcd8544_spi_receiver

Overview:
- Display-side end of the Nokia 5110 SPI link: receives SCE/SCLK/MOSI/D_C as driven by the screen controller and decodes them exactly as the PCD8544 would.
- Assembles bytes, interprets command bytes (function set, addressing, display control, Vop, bias, temperature coefficient) and turns data bytes into addressed frame-buffer writes.
- Used as an on-FPGA display mirror and as the loopback checker for the screen controller.

Parameters:
- NB_COLUMNS, 84, columns per bank; X address range 0..NB_COLUMNS-1.
- NB_BANKS, 6, 8-pixel banks; Y address range 0..NB_BANKS-1.
- SYNC_STAGES, 2, synchroniser flops on each SPI input.

Ports:
- clk_main  input  1  system clock; must be at least 4x the SCLK frequency.
- rst_n  input  1  asynchronous active-low reset.
- spi_sce  input  1  chip enable, active low, asynchronous to clk_main.
- spi_clk  input  1  SPI clock; MOSI is sampled on its rising edge.
- spi_mosi  input  1  serial data, MSB first.
- spi_d_c  input  1  1 = data byte, 0 = command byte; sampled with bit 0.
- fb_wr_en  output  1  one-cycle pulse: frame-buffer write.
- fb_x  output  7  column of the write.
- fb_y  output  3  bank of the write.
- fb_data  output  8  pixel byte; bit 0 is the top pixel.
- frame_done  output  1  one-cycle pulse, coincident with the write to the last address of the active addressing order.
- disp_mode  output  2  {D,E} from display control: 00 blank, 10 normal, 01 all on, 11 inverse.
- power_down  output  1  PD bit of function set.
- vop  output  7  operating voltage setting.
- bias  output  3  bias system setting.
- temp_coef  output  2  temperature coefficient.
- byte_err  output  1  one-cycle pulse: SCE rose with 1..7 bits pending.

Behaviour:
- Reset values (rst_n low, asynchronous): all outputs 0, except power_down=1. Internal state: X=0, Y=0, H=0, V=0, bit count 0, state IDLE.
- Input conditioning:
  - All four SPI inputs pass through SYNC_STAGES flops.
  - Rising SCLK edge = synchronised spi_clk goes 0 to 1 between consecutive clk_main cycles.
  - Edges seen while synchronised SCE=1 are ignored.
- FSM IDLE:
  - SCE=1, bit count held at 0.
  - SCE falling moves to SHIFT.
- FSM SHIFT:
  - Each rising SCLK shifts MOSI into shift_reg[0]; the register shifts left.
  - D_C is captured on the 8th edge.
  - After the 8th edge, go to DISPATCH.
  - SCE rising returns to IDLE. If bit count is 1..7, pulse byte_err and discard the partial byte.
- FSM DISPATCH (exactly one cycle):
  - Act on the byte, clear the bit count.
  - Return to SHIFT, or to IDLE if SCE=1.
  - Latency: the last SCLK edge at the synchroniser output is followed by the fb_wr_en / register update 2 clk_main cycles later.
- Data byte (D_C=1):
  - Pulse fb_wr_en with fb_x=X, fb_y=Y, fb_data=byte.
  - V=0 (horizontal): X++. At X=NB_COLUMNS-1, set X=0 and Y++. Y wraps NB_BANKS-1 to 0.
  - V=1 (vertical): Y++. At Y=NB_BANKS-1, set Y=0 and X++. X wraps to 0.
  - frame_done pulses when the write is at X=83,Y=5.
- Command byte (D_C=0), matched by priority on the leading 1:
  - 0000_0000: NOP.
  - 0010_0PVH: power_down=P, V, H. Accepted in both instruction sets.
  - H=0:
    - 0000_1D0E: disp_mode={D,E}.
    - 0100_0yyy: Y=yyy, ignored if yyy>5.
    - 1xxx_xxxx: X=xxxxxxx, ignored if >83.
  - H=1:
    - 0000_01tt: temp_coef=tt.
    - 0001_0bbb: bias=bbb.
    - 1vvv_vvvv: vop=vvvvvvv.
  - Any other pattern is ignored with no state change.
- Boundary conditions:
  - X/Y setting commands change the auto-increment pointer only; they generate no write.
  - Writes and address updates are unaffected by power_down.
  - A D_C change mid-byte has no effect; only the 8th-bit sample counts.
  - SCE rising in the same cycle as DISPATCH: the byte is processed, then the FSM goes to IDLE. No byte_err.
  - rst_n asserted mid-byte: immediate return to reset values; the partial byte is lost.

Decomposition:
- Shared package pcd8544_pkg:
  - FSM state enum (IDLE, SHIFT, DISPATCH).
  - Command opcode masks/values.
  - NB_COLUMNS/NB_BANKS defaults.
  - disp_mode encodings.
- One sub-module, spi_input_sync: synchroniser plus SCLK rising-edge / SCE edge detector. Decode and address logic stay in the top.

Test Plan:
- Init sequence 0x21, 0xBF, 0x14, 0x06, 0x20, 0x0C (D_C=0) -> vop=0x3F, bias=4, temp_coef=2, H=0, power_down=0, disp_mode=2'b10.
- V=0: 0x80 then 0x41, then data 0xA5, 0x5A -> writes (0,1,A5) then (1,1,5A). From X=83,Y=5, a data byte -> write (83,5), frame_done=1, next write lands at (0,0).
- Function set 0x22 (V=1), 0x80, 0x45, then three data bytes -> writes at (0,5), (1,0), (1,1).
- 0x80|90 (X=90) then 0x47 (Y=7), then data 0x33 -> write at the previous X,Y; no change.
- SCE rises after 5 bits -> byte_err pulse, no write. A following full byte 0xFF data decodes correctly.
- rst_n low mid-byte, then release and send a data byte -> write at (0,0), power_down=1, vop=0.
